icache: RTL

Direct-mapped, one-word-per-block instruction cache between the datapath fetch port and the memory controller's instruction port. It answers the program counter's fetch requests (`imemREN`/`imemaddr`) with `ihit`/`imemload` in the same cycle on a hit. On a miss it runs a single-outstanding fill over the `iREN`/`iaddr`/`iwait`/`iload` handshake. Read-only; no write path.

---
 rtl/icache.sv | 115 +++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache.
// Hits are answered combinationally in IDLE. A miss runs a single
// outstanding fill over the iREN/iwait handshake in FETCH.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx_c;
  logic [TAG_W-1:0]  req_tag_c;
  logic [IDX_W-1:0]  fill_idx_c;
  logic [TAG_W-1:0]  fill_tag_c;
  logic              lookup_hit_c;
  logic              fill_we_c;

  // Address split for the live fetch and for the latched miss address.
  assign req_idx_c  = imemaddr[IDX_W+1:2];
  assign req_tag_c  = imemaddr[31:IDX_W+2];
  assign fill_idx_c = maddr_q[IDX_W+1:2];
  assign fill_tag_c = maddr_q[31:IDX_W+2];

  // Tag compare against the indexed set.
  assign lookup_hit_c = imemREN & valid_q[req_idx_c] &
                        (tag_q[req_idx_c] == req_tag_c);

  // State and miss-address registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
    end
  end

  // Next-state and output logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    maddr_d   = maddr_q;
    fill_we_c = 1'b0;
    ihit      = 1'b0;
    imemload  = '0;
    iREN      = 1'b0;
    iaddr     = '0;
    case (state_q)
      IDLE: begin
        if (!iflush) begin
          if (lookup_hit_c) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx_c];
          end else if (imemREN) begin
            maddr_d = imemaddr & 32'hFFFF_FFFC;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = maddr_q;
        if (!iwait) begin
          fill_we_c = !iflush;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (iflush) begin
      state_d = IDLE;
    end
  end

  // Cache storage: flush clears valid bits, a completing fill installs a block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (iflush) begin
      valid_q <= '0;
    end else if (fill_we_c) begin
      valid_q[fill_idx_c] <= 1'b1;
      tag_q[fill_idx_c]   <= fill_tag_c;
      data_q[fill_idx_c]  <= iload;
    end
  end

endmodule
